// File: rtl/tx_data_fifo_sync_v2.sv
// Single-clock TX data FIFO: generic width/depth, block-RAM storage,
// registered read data, level counter and registered status flags.
module tx_data_fifo_sync_v2 #(
  parameter int DW     = 32,
  parameter int AW     = 10,
  parameter int AF_LVL = (2**AW) - 4,
  parameter int AE_LVL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW:0]   level_next;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    level_next = level;
    if (flush)
      level_next = '0;
    else if (wr_acc & ~rd_acc)
      level_next = level + ONE_L;
    else if (rd_acc & ~wr_acc)
      level_next = level - ONE_L;
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      dout         <= '0;
      dout_vld     <= 1'b0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc)
          wptr <= wptr + AW'(1);
        if (rd_acc)
          rptr <= rptr + AW'(1);
      end
      if (rd_acc)
        dout <= mem[rptr];
      dout_vld     <= rd_acc;
      level        <= level_next;
      full         <= (level_next == DEPTH_L);
      empty        <= (level_next == '0);
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
      overflow     <= wr_en & full & ~flush;
      underflow    <= rd_en & empty & ~flush;
    end
  end

endmodule
